ka_operand_split_issue: RTL

- Front-end counterpart of the Karatsuba partial-product recombiner.
- Accepts one N-bit operand pair over a valid/ready handshake and splits each operand into H=N/2-bit halves.
- Issues the three Karatsuba sub-multiplication operand pairs (low, high, middle XOR) one at a time to a shared downstream H×H GF(2) multiplier.
- Each issue is tagged, so the product collector routes the low product to recombiner input 1, the middle product to input 2 and the high product to input 3.

---
 rtl/ka_operand_split_issue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ka_operand_split_issue.sv
// ----------------------------------------------------------------------------
// ka_operand_split_issue
//
// Front end of a Karatsuba GF(2) multiplier. The block accepts one N-bit
// operand pair and issues three H x H sub-multiplication operand pairs
// (H = N/2) to a shared downstream carry-less multiplier. Each pair carries a
// tag, so the product collector can route the result to the right recombiner
// input:
//   tag 0 : low halves            (a_lo, b_lo)
//   tag 1 : high halves           (a_hi, b_hi)
//   tag 2 : middle, XOR of halves (a_lo ^ a_hi, b_lo ^ b_hi), out_last = 1
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand-pair handshake (a_in, b_in are N bits)
//   out_valid / out_ready sub-operand handshake (out_a, out_b are H bits)
//   out_tag               sub-product identifier (0 low, 1 high, 2 middle)
//   out_last              high on the middle issue, which is the last one
//   busy                  an operation is in progress
//   op_count              completed operations (middle handshakes), wrapping
// ----------------------------------------------------------------------------
module ka_operand_split_issue #(
  parameter int N     = 42,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         a_in,
  input  logic [N-1:0]         b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N/2-1:0]       out_a,
  output logic [N/2-1:0]       out_b,
  output logic [1:0]           out_tag,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int H = N / 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISS_LO  = 2'd1;
  localparam logic [1:0] ISS_HI  = 2'd2;
  localparam logic [1:0] ISS_MID = 2'd3;

  localparam logic [1:0] TAG_LO  = 2'd0;
  localparam logic [1:0] TAG_HI  = 2'd1;
  localparam logic [1:0] TAG_MID = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_next;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;

  logic         accept;
  logic         issue_done;

  // Handshakes. in_ready looks at out_ready combinationally so that a new
  // pair can be taken in the same cycle as the middle issue completes,
  // giving one operation every three cycles with no bubble.
  assign in_ready   = (state == IDLE) || ((state == ISS_MID) && out_ready);
  assign accept     = in_valid && in_ready;
  assign issue_done = out_valid && out_ready;
  assign busy       = (state != IDLE);

  // Next-state logic.
  // NOTE: state_next gets a default before the case so that no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = ISS_LO;
      ISS_LO:  if (issue_done) state_next = ISS_HI;
      ISS_HI:  if (issue_done) state_next = ISS_MID;
      ISS_MID: if (issue_done) state_next = accept ? ISS_LO : IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // State, operand capture and completed-operation counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      op_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg <= a_in;
        b_reg <= b_in;
      end
      if ((state == ISS_MID) && issue_done) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

  // Issue datapath. Outputs are decoded from the registered state and the
  // captured operands. Operands only change on accept, which cannot happen
  // while an issue is stalled, so outputs stay stable under backpressure.
  always_comb begin
    out_valid = 1'b0;
    out_a     = '0;
    out_b     = '0;
    out_tag   = TAG_LO;
    out_last  = 1'b0;
    case (state)
      ISS_LO: begin
        out_valid = 1'b1;
        out_a     = a_reg[H-1:0];
        out_b     = b_reg[H-1:0];
        out_tag   = TAG_LO;
      end
      ISS_HI: begin
        out_valid = 1'b1;
        out_a     = a_reg[N-1:H];
        out_b     = b_reg[N-1:H];
        out_tag   = TAG_HI;
      end
      ISS_MID: begin
        // GF(2) addition of the halves: XOR only, no carries.
        out_valid = 1'b1;
        out_a     = a_reg[H-1:0] ^ a_reg[N-1:H];
        out_b     = b_reg[H-1:0] ^ b_reg[N-1:H];
        out_tag   = TAG_MID;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
